// File: rtl/loader_pkg.sv
// Shared definitions for the serial instruction loader and the core it feeds.
package loader_pkg;

   // Instruction width shared with the cpu INSTRUCTION port.
   localparam int unsigned WIDTH = 8;

   // Widest frame (data + parity) the parity helper accepts.
   localparam int unsigned PAR_MAX = 64;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      PARITY
   } state_t;

   // XOR of all bits. The caller zero-extends its frame to PAR_MAX bits.
   // The result is 0 when the frame carries even parity.
   function automatic logic parity_of(input logic [PAR_MAX-1:0] bits);
      return ^bits;
   endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Signal bundle between the serial host/core side and instr_loader.
// The master modport is the host/core side. The slave modport is the loader.
interface instr_loader_if #(
   parameter int unsigned WIDTH = loader_pkg::WIDTH,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned LW = $clog2(DEPTH) + 1;

   logic             SDI;
   logic             SVALID;
   logic             SFRAME;
   logic             CPU_READY;
   logic             CLR_ERR;
   logic [WIDTH-1:0] INSTRUCTION;
   logic             WRITE_EN;
   logic             FULL;
   logic             EMPTY;
   logic [LW-1:0]    LEVEL;
   logic             PAR_ERR;
   logic             OVERFLOW;

   modport master (
      output SDI, SVALID, SFRAME, CPU_READY, CLR_ERR,
      input  INSTRUCTION, WRITE_EN, FULL, EMPTY, LEVEL, PAR_ERR, OVERFLOW
   );

   modport slave (
      input  SDI, SVALID, SFRAME, CPU_READY, CLR_ERR,
      output INSTRUCTION, WRITE_EN, FULL, EMPTY, LEVEL, PAR_ERR, OVERFLOW
   );

endinterface

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO. The pointers are one bit wider than the index.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
   parameter int unsigned WIDTH = loader_pkg::WIDTH,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     RESET_N,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Pointer update. Both pointers wrap naturally modulo 2*DEPTH.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write. The contents need no reset because the pointers gate validity.
   always_ff @(posedge CLK) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

   assign dout  = mem[rd_ptr[AW-1:0]];
   assign level = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (level == FULL_LVL);

endmodule

// File: rtl/instr_loader.sv
// Serial instruction loader. It deserialises parity-protected frames into a FIFO
// and strobes them out to the core one at a time, with a gap of at least one cycle.
module instr_loader #(
   parameter int unsigned WIDTH = loader_pkg::WIDTH,
   parameter int unsigned DEPTH = 4
) (
   input  logic           CLK,
   input  logic           RESET_N,
   instr_loader_if.slave  bus
);
   import loader_pkg::*;

   localparam int unsigned CW = $clog2(WIDTH);
   localparam int unsigned LW = $clog2(DEPTH) + 1;

   state_t           state_q, state_d;
   logic [CW-1:0]    bitcnt_q, bitcnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             push;
   logic             par_bad;
   logic             pop;
   logic             ovf_evt;

   logic [WIDTH-1:0] fifo_dout;
   logic             fifo_full;
   logic             fifo_empty;
   logic [LW-1:0]    fifo_level;

   logic [WIDTH-1:0] instr_q;
   logic             we_q;
   logic             par_err_q;
   logic             ovf_q;

   // Deserialiser state, bit counter and shift register.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= IDLE;
         bitcnt_q <= '0;
         shreg_q  <= '0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         shreg_q  <= shreg_d;
      end
   end

   // Frame sequencing. SFRAME restarts from any state and overrides SVALID.
   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shreg_d  = shreg_q;
      push     = 1'b0;
      par_bad  = 1'b0;
      if (bus.SFRAME) begin
         state_d  = SHIFT;
         bitcnt_d = '0;
         shreg_d  = '0;
      end else if (bus.SVALID) begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            SHIFT: begin
               shreg_d  = {shreg_q[WIDTH-2:0], bus.SDI};
               bitcnt_d = bitcnt_q + 1'b1;
               if (bitcnt_q == CW'(WIDTH - 1)) state_d = PARITY;
            end
            PARITY: begin
               state_d = IDLE;
               if (parity_of(PAR_MAX'({shreg_q, bus.SDI}))) par_bad = 1'b1;
               else                                         push    = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // The !we_q term forces at least one idle cycle between strobes.
   assign pop     = !fifo_empty && bus.CPU_READY && !we_q;
   assign ovf_evt = push && fifo_full && !pop;

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .push    (push),
      .pop     (pop),
      .din     (shreg_q),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // Output register: capture the FIFO head on pop and raise a one-cycle strobe.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         instr_q <= '0;
         we_q    <= 1'b0;
      end else begin
         we_q <= pop;
         if (pop) instr_q <= fifo_dout;
      end
   end

   // Sticky fault flags. A set event beats a simultaneous clear.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         par_err_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         if (par_bad)          par_err_q <= 1'b1;
         else if (bus.CLR_ERR) par_err_q <= 1'b0;
         if (ovf_evt)          ovf_q <= 1'b1;
         else if (bus.CLR_ERR) ovf_q <= 1'b0;
      end
   end

   assign bus.INSTRUCTION = instr_q;
   assign bus.WRITE_EN    = we_q;
   assign bus.FULL        = fifo_full;
   assign bus.EMPTY       = fifo_empty;
   assign bus.LEVEL       = fifo_level;
   assign bus.PAR_ERR     = par_err_q;
   assign bus.OVERFLOW    = ovf_q;

endmodule

// File: doc/instr_loader.md
# instr_loader

Serial instruction loader sitting directly upstream of `cpu`. It deserialises framed, parity-protected instruction bytes from a slow serial pin stream into a small FIFO. It then presents them one at a time on `INSTRUCTION` with a one-cycle `WRITE_EN` strobe whenever the core signals readiness. It absorbs rate mismatch between the external host and the core, and reports parity and overflow faults.

## Interface
Parameters:
- `WIDTH`, 8: instruction width in bits; equals `cpu` `INSTRUCTION` width.
- `DEPTH`, 4: FIFO entries; must be a power of two, at least 2.

Ports:
- `CLK`  in  1  single system clock; rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `SDI`  in  1  serial data bit, MSB first.
- `SVALID`  in  1  `SDI` is valid this cycle.
- `SFRAME`  in  1  start-of-frame pulse; carries no data bit.
- `CPU_READY`  in  1  core can accept an instruction this cycle.
- `CLR_ERR`  in  1  clears the sticky flags.
- `INSTRUCTION`  out  WIDTH  registered instruction to the core.
- `WRITE_EN`  out  1  one-cycle strobe; `INSTRUCTION` is valid while high.
- `FULL`, `EMPTY`  out  1  FIFO status.
- `LEVEL`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `PAR_ERR`  out  1  sticky; set when a frame was dropped for a parity mismatch.
- `OVERFLOW`  out  1  sticky; set when a good frame was dropped because the FIFO was full.

## Operation
- Frame format: `SFRAME`, then WIDTH data bits, then 1 even-parity bit. The XOR of all WIDTH+1 bits must equal 0. Each bit is qualified by `SVALID`; gaps of any length between bits are legal.
- FSM states: IDLE, SHIFT, PARITY.
  - IDLE: `SFRAME` moves to SHIFT, clears `bitcnt` and the shift register. `SVALID` without a preceding `SFRAME` is ignored.
  - SHIFT: each `SVALID` shifts `SDI` into the LSB (`shreg <= {shreg[WIDTH-2:0], SDI}`) and increments `bitcnt`. The cycle that accepts bit WIDTH-1 moves to PARITY.
  - PARITY: `SVALID` samples the parity bit, then returns to IDLE.
    - Parity good: a push of `shreg` is issued in that same cycle.
    - Parity bad: the frame is dropped and `PAR_ERR` is set.
- `SFRAME` in SHIFT or PARITY discards the partial frame and restarts in SHIFT with `bitcnt` = 0. No flag is set. `SFRAME` takes priority over a simultaneous `SVALID`.
- FIFO: circular buffer of DEPTH entries with pointers one bit wider than the index. Both pointers wrap modulo 2·DEPTH.
- Push when full sets `OVERFLOW` and drops the frame. Exception: a pop in the same cycle makes room, so the push is accepted and `LEVEL` stays unchanged.
- Pop condition: `!EMPTY && CPU_READY && !WRITE_EN`. The `!WRITE_EN` term guarantees at least one idle cycle between strobes, giving `cpu` a cycle to latch.
- On pop, `INSTRUCTION <= mem[rd_ptr]` and `WRITE_EN <= 1` on the next edge. `INSTRUCTION` holds its value until the next pop.
- `CLR_ERR` clears both sticky flags. If a set event occurs in the same cycle, set wins.

## Timing
- Reset values: `INSTRUCTION` = 0, `WRITE_EN` = 0, `EMPTY` = 1, `FULL` = 0, `LEVEL` = 0, `PAR_ERR` = 0, `OVERFLOW` = 0. Reset also puts the FSM in IDLE and zeroes both pointers.
- Reset asserted mid-frame or mid-strobe aborts everything immediately (asynchronous). FIFO contents are lost logically.
- Latency from a good parity bit sampled in cycle N, with the FIFO empty and `CPU_READY` high:
  - entry written at edge N+1;
  - `EMPTY` low during cycle N+1;
  - pop issued in cycle N+1;
  - `WRITE_EN` high in cycle N+2.
- Back-to-back drain with `CPU_READY` held high: one strobe every 2 cycles.
- `FULL`, `EMPTY`, `LEVEL` are registered and reflect pushes and pops from the previous edge.
- `WRITE_EN` is never high for two consecutive cycles.

## Structure
- Shared package `loader_pkg`:
  - FSM state enum (IDLE, SHIFT, PARITY);
  - `WIDTH` default constant, used by both `cpu` and this block;
  - parity-function helper.
- One sub-module: `sync_fifo` (parameters WIDTH, DEPTH; ports push/pop/din/dout/full/empty/level). `instr_loader` contains the deserialiser FSM, the sticky flags, and the output register.

## Test plan
- Reset → all outputs at their reset values. Then frame `SFRAME`, bits 1,0,1,0,0,1,0,1, parity 0 (0xA5), `CPU_READY` = 1 → `WRITE_EN` pulses once, 2 cycles after the parity bit, with `INSTRUCTION` = 0xA5.
- Frame 0x03 with parity bit 1 (wrong) → no `WRITE_EN`, `PAR_ERR` = 1 and stays set. `CLR_ERR` pulse → `PAR_ERR` = 0.
- `CPU_READY` = 0; send 5 good frames 0x01..0x05 → `FULL` = 1 after the 4th, `OVERFLOW` = 1 after the 5th. Raise `CPU_READY` → strobes deliver 0x01, 0x02, 0x03, 0x04 in order, 2 cycles apart; `EMPTY` = 1 afterwards.
- FIFO full; a good frame's parity bit coincides with a pop → no `OVERFLOW`, `LEVEL` stays at 4, the new byte is delivered last.
- `SFRAME` after 3 data bits, then a full frame 0x3C → only 0x3C is delivered, no flags set.
- `RESET_N` low during SHIFT with 2 entries queued → outputs return to reset values, no strobes afterwards, and the next frame 0x7E is delivered normally.
